// File: rtl/board_lock_clear_if.sv
// Request/response bundle for the playfield state holder.
// master: piece decoder / control side (drives cells, geometry, requests, read address)
// slave : board_lock_clear (returns status pulses, collision, line count, read data)
interface board_lock_clear_if;
  logic       Clr_Board;
  logic [7:0] Cur_1;
  logic [7:0] Cur_2;
  logic [7:0] Cur_3;
  logic [7:0] Cur_4;
  logic [3:0] Pos_X;
  logic [4:0] Pos_Y;
  logic [2:0] Width;
  logic [2:0] Height;
  logic       Check_Req;
  logic       Lock_Req;
  logic       Busy;
  logic       Check_Done;
  logic       Collide;
  logic       Lock_Done;
  logic [2:0] Lines_Cleared;
  logic       Top_Out;
  logic [7:0] Rd_Addr;
  logic       Rd_Data;

  modport master (
    output Clr_Board, Cur_1, Cur_2, Cur_3, Cur_4, Pos_X, Pos_Y, Width, Height,
           Check_Req, Lock_Req, Rd_Addr,
    input  Busy, Check_Done, Collide, Lock_Done, Lines_Cleared, Top_Out, Rd_Data
  );

  modport slave (
    input  Clr_Board, Cur_1, Cur_2, Cur_3, Cur_4, Pos_X, Pos_Y, Width, Height,
           Check_Req, Lock_Req, Rd_Addr,
    output Busy, Check_Done, Collide, Lock_Done, Lines_Cleared, Top_Out, Rd_Data
  );
endinterface

// File: rtl/board_lock_clear.sv
// Playfield state holder: answers collision queries, locks landed pieces,
// then scans bottom-up and clears full rows by shifting upper rows down.
// Ports:
//   Clk, Rst : clock and synchronous active-high reset
//   bus      : board_lock_clear_if.slave (cells, geometry, Check/Lock requests,
//              status pulses, Collide, Lines_Cleared, Top_Out, display read port)
module board_lock_clear #(
  parameter int unsigned BLOCKS_WIDE = 14,
  parameter int unsigned BLOCKS_HIGH = 18,
  parameter logic [7:0]  EMPTY_CELL  = 8'hFF
) (
  input  logic               Clk,
  input  logic               Rst,
  board_lock_clear_if.slave  bus
);

  localparam int unsigned NCELLS  = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = 4;
  localparam int unsigned BND_W   = 6;

  typedef enum logic [2:0] {IDLE, CHECK, LOCK, SCAN, SHIFT, DONE} state_e;

  // Row-major storage: bit c of row r is cell r*BLOCKS_WIDE+c in the flattened view
  logic [BLOCKS_HIGH-1:0][BLOCKS_WIDE-1:0] board_q, board_d;
  state_e                                  state_q, state_d;
  logic [ROW_W-1:0]                        row_q, row_d;
  logic [ROW_W-1:0]                        k_q, k_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [3:0][7:0]                         cells_q, cells_d;
  logic                                    busy_q, busy_d;
  logic                                    check_done_q, check_done_d;
  logic                                    collide_q, collide_d;
  logic                                    lock_done_q, lock_done_d;
  logic [CNT_W-1:0]                        lines_q, lines_d;
  logic                                    top_out_q, top_out_d;

  logic [3:0][7:0] cur_in;
  logic [255:0]    cell_vec;
  logic [255:0]    lock_vec;
  logic [BND_W-1:0] x_end_c, y_end_c;
  logic            hit_c;
  logic            collide_c;
  logic            shift_end_c;

  assign cur_in = {bus.Cur_4, bus.Cur_3, bus.Cur_2, bus.Cur_1};

  // Zero-padded flat view: indices 252..255 always read as empty
  assign cell_vec = 256'(board_q);

  // Collision against live inputs; the board is stable while IDLE so the
  // answer can be registered on the accepting edge
  always_comb begin
    x_end_c = BND_W'(bus.Pos_X) + BND_W'(bus.Width);
    y_end_c = BND_W'(bus.Pos_Y) + BND_W'(bus.Height);
    hit_c   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur_in[i] != EMPTY_CELL && cell_vec[cur_in[i]]) hit_c = 1'b1;
    end
    collide_c = (bus.Width != 3'd0) &&
                ((x_end_c > BND_W'(BLOCKS_WIDE)) ||
                 (y_end_c > BND_W'(BLOCKS_HIGH)) || hit_c);
  end

  // Next-state and output computation
  always_comb begin
    board_d      = board_q;
    state_d      = state_q;
    row_d        = row_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    cells_d      = cells_q;
    check_done_d = 1'b0;
    collide_d    = collide_q;
    lock_done_d  = 1'b0;
    lines_d      = lines_q;
    top_out_d    = top_out_q;
    lock_vec     = cell_vec;
    shift_end_c  = 1'b0;

    case (state_q)
      IDLE: begin
        // Lock has priority; a simultaneous check is dropped
        if (bus.Lock_Req) begin
          cells_d = cur_in;
          state_d = LOCK;
        end else if (bus.Check_Req) begin
          cells_d      = cur_in;
          collide_d    = collide_c;
          check_done_d = 1'b1;
          state_d      = CHECK;
        end
      end
      CHECK: state_d = IDLE;
      LOCK: begin
        for (int i = 0; i < 4; i++) begin
          if (cells_q[i] < 8'(NCELLS)) lock_vec[cells_q[i]] = 1'b1;
        end
        board_d = lock_vec[NCELLS-1:0];
        cnt_d   = '0;
        row_d   = ROW_W'(BLOCKS_HIGH - 1);
        state_d = SCAN;
      end
      SCAN: begin
        if (&board_q[row_q]) begin
          k_d     = row_q;
          state_d = SHIFT;
        end else if (row_q == '0) begin
          lock_done_d = 1'b1;
          lines_d     = cnt_q;
          top_out_d   = top_out_q | (|board_q[0]);
          state_d     = DONE;
        end else begin
          row_d = row_q - ROW_W'(1);
        end
      end
      SHIFT: begin
        if (k_q == '0) begin
          board_d[0]  = '0;
          shift_end_c = 1'b1;
        end else begin
          board_d[k_q] = board_q[k_q - ROW_W'(1)];
          if (k_q == ROW_W'(1)) begin
            board_d[0]  = '0;
            shift_end_c = 1'b1;
          end else begin
            k_d = k_q - ROW_W'(1);
          end
        end
        // Rescan the same row: the collapsed row above may also be full
        if (shift_end_c) begin
          if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
          state_d = SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; wipe aborts any operation in flight
  always_ff @(posedge Clk) begin
    if (Rst || bus.Clr_Board) begin
      board_q      <= '0;
      state_q      <= IDLE;
      row_q        <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      cells_q      <= '0;
      busy_q       <= 1'b0;
      check_done_q <= 1'b0;
      collide_q    <= 1'b0;
      lock_done_q  <= 1'b0;
      lines_q      <= '0;
      top_out_q    <= 1'b0;
    end else begin
      board_q      <= board_d;
      state_q      <= state_d;
      row_q        <= row_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      cells_q      <= cells_d;
      busy_q       <= busy_d;
      check_done_q <= check_done_d;
      collide_q    <= collide_d;
      lock_done_q  <= lock_done_d;
      lines_q      <= lines_d;
      top_out_q    <= top_out_d;
    end
  end

  assign bus.Busy          = busy_q;
  assign bus.Check_Done    = check_done_q;
  assign bus.Collide       = collide_q;
  assign bus.Lock_Done     = lock_done_q;
  assign bus.Lines_Cleared = lines_q;
  assign bus.Top_Out       = top_out_q;
  assign bus.Rd_Data       = cell_vec[bus.Rd_Addr];

endmodule

// File: tb/tb_board_lock_clear.sv
// Directed bench for board_lock_clear: collision queries, lock latency,
// single and quadruple line clears, request arbitration, reset mid-shift, Top_Out.
module tb_board_lock_clear;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  board_lock_clear_if bus();

  board_lock_clear dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cells(input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3, input logic [7:0] c4);
    bus.Cur_1 = c1;
    bus.Cur_2 = c2;
    bus.Cur_3 = c3;
    bus.Cur_4 = c4;
  endtask

  // Drive a check request for one edge; returns just after the accepting edge
  task automatic do_check(input logic [7:0] c1, input logic [7:0] c2,
                          input logic [7:0] c3, input logic [7:0] c4,
                          input logic [3:0] px, input logic [4:0] py,
                          input logic [2:0] w, input logic [2:0] h);
    set_cells(c1, c2, c3, c4);
    bus.Pos_X     = px;
    bus.Pos_Y     = py;
    bus.Width     = w;
    bus.Height    = h;
    bus.Check_Req = 1'b1;
    tick();
    bus.Check_Req = 1'b0;
  endtask

  // Lock and wait for Lock_Done; lat = cycle index of the pulse (1 = first
  // cycle after accept), 0 when it never arrives. Ends back in IDLE.
  task automatic do_lock(input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] c4,
                         input bit with_check, output int lat, output bit saw_check);
    set_cells(c1, c2, c3, c4);
    bus.Lock_Req  = 1'b1;
    bus.Check_Req = with_check;
    tick();
    bus.Lock_Req  = 1'b0;
    bus.Check_Req = 1'b0;
    lat       = 0;
    saw_check = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (bus.Check_Done) saw_check = 1'b1;
      if (bus.Lock_Done) begin
        lat = n;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.Busy); end
    n_checks++; if (bus.Top_Out !== 1'b0) begin n_fail++; $display("FAIL rst_top_out: got %b expected 0", bus.Top_Out); end
    n_checks++; if (bus.Lines_Cleared !== 3'd0) begin n_fail++; $display("FAIL rst_lines: got %0d expected 0", bus.Lines_Cleared); end
    n_checks++; if (bus.Check_Done !== 1'b0 || bus.Lock_Done !== 1'b0 || bus.Collide !== 1'b0) begin
      n_fail++; $display("FAIL rst_pulses: got cd=%b ld=%b col=%b expected 0 0 0", bus.Check_Done, bus.Lock_Done, bus.Collide);
    end
    rst = 1'b0;
    for (int a = 0; a < 256; a++) begin
      bus.Rd_Addr = 8'(a);
      #1;
      n_checks++; if (bus.Rd_Data !== 1'b0) begin n_fail++; $display("FAIL rst_board addr=%0d: got %b expected 0", a, bus.Rd_Data); end
    end
    tick();
    do_check(8'd196, 8'd210, 8'd224, 8'd238, 4'd0, 5'd14, 3'd1, 3'd4);
    n_checks++; if (bus.Check_Done !== 1'b1) begin n_fail++; $display("FAIL chk_i_done: got %b expected 1", bus.Check_Done); end
    n_checks++; if (bus.Collide !== 1'b0) begin n_fail++; $display("FAIL chk_i_collide: got %b expected 0", bus.Collide); end
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL chk_i_busy: got %b expected 1", bus.Busy); end
    tick();
    n_checks++; if (bus.Check_Done !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL chk_i_end: got cd=%b busy=%b expected 0 0", bus.Check_Done, bus.Busy);
    end
  endtask

  task automatic test_bounds();
    // Below the floor: Pos_Y 15 + Height 4 = 19
    do_check(8'd210, 8'd224, 8'd238, 8'd252, 4'd0, 5'd15, 3'd1, 3'd4);
    n_checks++; if (bus.Check_Done !== 1'b1 || bus.Collide !== 1'b1) begin
      n_fail++; $display("FAIL bnd_floor: got cd=%b col=%b expected 1 1", bus.Check_Done, bus.Collide);
    end
    tick();
    // Past the right wall: 11 + 4 = 15
    do_check(8'd11, 8'd12, 8'd13, 8'd14, 4'd11, 5'd0, 3'd4, 3'd1);
    n_checks++; if (bus.Check_Done !== 1'b1 || bus.Collide !== 1'b1) begin
      n_fail++; $display("FAIL bnd_right: got cd=%b col=%b expected 1 1", bus.Check_Done, bus.Collide);
    end
    tick();
    // Exactly flush with the right wall: 10 + 4 = 14
    do_check(8'd10, 8'd11, 8'd12, 8'd13, 4'd10, 5'd0, 3'd4, 3'd1);
    n_checks++; if (bus.Check_Done !== 1'b1 || bus.Collide !== 1'b0) begin
      n_fail++; $display("FAIL bnd_flush: got cd=%b col=%b expected 1 0", bus.Check_Done, bus.Collide);
    end
    tick();
    // Empty shape never collides even with wild position
    do_check(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd15, 5'd31, 3'd0, 3'd7);
    n_checks++; if (bus.Check_Done !== 1'b1 || bus.Collide !== 1'b0) begin
      n_fail++; $display("FAIL bnd_empty: got cd=%b col=%b expected 1 0", bus.Check_Done, bus.Collide);
    end
    tick();
  endtask

  task automatic test_lock_o();
    int lat;
    bit saw;
    logic [255:0] exp;
    do_lock(8'd224, 8'd225, 8'd238, 8'd239, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL lock_o_latency: got %0d expected 20", lat); end
    n_checks++; if (bus.Lines_Cleared !== 3'd0) begin n_fail++; $display("FAIL lock_o_lines: got %0d expected 0", bus.Lines_Cleared); end
    n_checks++; if (bus.Busy !== 1'b0 || bus.Top_Out !== 1'b0) begin
      n_fail++; $display("FAIL lock_o_status: got busy=%b top=%b expected 0 0", bus.Busy, bus.Top_Out);
    end
    exp = '0;
    exp[224] = 1'b1; exp[225] = 1'b1; exp[238] = 1'b1; exp[239] = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bus.Rd_Addr = 8'(a);
      #1;
      n_checks++; if (bus.Rd_Data !== exp[a]) begin n_fail++; $display("FAIL lock_o_board addr=%0d: got %b expected %b", a, bus.Rd_Data, exp[a]); end
    end
    tick();
    do_check(8'd224, 8'd225, 8'd238, 8'd239, 4'd0, 5'd16, 3'd2, 3'd2);
    n_checks++; if (bus.Check_Done !== 1'b1 || bus.Collide !== 1'b1) begin
      n_fail++; $display("FAIL lock_o_overlap: got cd=%b col=%b expected 1 1", bus.Check_Done, bus.Collide);
    end
    tick(); tick(); tick();
    n_checks++; if (bus.Collide !== 1'b1) begin n_fail++; $display("FAIL collide_hold: got %b expected 1", bus.Collide); end
    do_check(8'd226, 8'd227, 8'd240, 8'd241, 4'd2, 5'd16, 3'd2, 3'd2);
    n_checks++; if (bus.Collide !== 1'b0) begin n_fail++; $display("FAIL lock_o_beside: got %b expected 0", bus.Collide); end
    tick();
  endtask

  task automatic test_clear_one();
    int lat;
    bit saw;
    logic [255:0] exp;
    do_lock(8'd240, 8'd241, 8'd242, 8'd243, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL fill1_a: got %0d expected 20", lat); end
    do_lock(8'd244, 8'd245, 8'd246, 8'd247, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL fill1_b: got %0d expected 20", lat); end
    do_lock(8'd248, 8'd249, 8'hFF, 8'hFF, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL fill1_c: got %0d expected 20", lat); end
    // Row 17 completes: 17 shift cycles plus a rescan of row 17
    do_lock(8'd250, 8'd251, 8'hFF, 8'hFF, 1'b0, lat, saw);
    n_checks++; if (lat !== 38) begin n_fail++; $display("FAIL clear1_latency: got %0d expected 38", lat); end
    n_checks++; if (bus.Lines_Cleared !== 3'd1) begin n_fail++; $display("FAIL clear1_lines: got %0d expected 1", bus.Lines_Cleared); end
    // Old row 16 (cols 0,1) has dropped into row 17
    exp = '0;
    exp[238] = 1'b1; exp[239] = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bus.Rd_Addr = 8'(a);
      #1;
      n_checks++; if (bus.Rd_Data !== exp[a]) begin n_fail++; $display("FAIL clear1_board addr=%0d: got %b expected %b", a, bus.Rd_Data, exp[a]); end
    end
    tick();
  endtask

  task automatic test_clear_four();
    int lat;
    bit saw;
    logic [7:0] c [4];
    int idx;
    bus.Clr_Board = 1'b1;
    tick();
    bus.Clr_Board = 1'b0;
    n_checks++; if (bus.Lines_Cleared !== 3'd0 || bus.Collide !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL wipe_status: got lines=%0d col=%b busy=%b expected 0 0 0", bus.Lines_Cleared, bus.Collide, bus.Busy);
    end
    for (int a = 0; a < 256; a++) begin
      bus.Rd_Addr = 8'(a);
      #1;
      n_checks++; if (bus.Rd_Data !== 1'b0) begin n_fail++; $display("FAIL wipe_board addr=%0d: got %b expected 0", a, bus.Rd_Data); end
    end
    // Rows 14..17, columns 0..12, four cells per lock
    for (int g = 0; g < 13; g++) begin
      for (int j = 0; j < 4; j++) begin
        idx  = g * 4 + j;
        c[j] = 8'((14 + idx / 13) * 14 + (idx % 13));
      end
      do_lock(c[0], c[1], c[2], c[3], 1'b0, lat, saw);
      n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL fill4 group=%0d: got %0d expected 20", g, lat); end
    end
    // 1 lock + 4*(1 scan + 17 shifts) + 18 scans + 1 done
    do_lock(8'd209, 8'd223, 8'd237, 8'd251, 1'b0, lat, saw);
    n_checks++; if (lat !== 92) begin n_fail++; $display("FAIL clear4_latency: got %0d expected 92", lat); end
    n_checks++; if (bus.Lines_Cleared !== 3'd4) begin n_fail++; $display("FAIL clear4_lines: got %0d expected 4", bus.Lines_Cleared); end
    n_checks++; if (bus.Top_Out !== 1'b0) begin n_fail++; $display("FAIL clear4_top: got %b expected 0", bus.Top_Out); end
    for (int a = 0; a < 256; a++) begin
      bus.Rd_Addr = 8'(a);
      #1;
      n_checks++; if (bus.Rd_Data !== 1'b0) begin n_fail++; $display("FAIL clear4_board addr=%0d: got %b expected 0", a, bus.Rd_Data); end
    end
    tick();
  endtask

  task automatic test_both_req();
    int lat;
    bit saw;
    do_lock(8'd238, 8'd239, 8'hFF, 8'hFF, 1'b1, lat, saw);
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL both_check_seen: got %b expected 0", saw); end
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL both_latency: got %0d expected 20", lat); end
    bus.Rd_Addr = 8'd238;
    #1;
    n_checks++; if (bus.Rd_Data !== 1'b1) begin n_fail++; $display("FAIL both_locked: got %b expected 1", bus.Rd_Data); end
    tick();
    n_checks++; if (bus.Check_Done !== 1'b0) begin n_fail++; $display("FAIL both_late_check: got %b expected 0", bus.Check_Done); end
  endtask

  task automatic test_busy_drop();
    int lat;
    bit saw;
    set_cells(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    bus.Lock_Req = 1'b1;
    tick();
    bus.Lock_Req = 1'b0;
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b expected 1", bus.Busy); end
    lat = 0;
    saw = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (bus.Check_Done) saw = 1'b1;
      if (bus.Lock_Done) begin
        lat = n;
        break;
      end
      bus.Check_Req = (n == 3);
      tick();
    end
    bus.Check_Req = 1'b0;
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL drop_check_seen: got %b expected 0", saw); end
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL drop_latency: got %0d expected 20", lat); end
    tick();
    n_checks++; if (bus.Check_Done !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_after: got cd=%b busy=%b expected 0 0", bus.Check_Done, bus.Busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    bit saw;
    bit seen_done;
    do_lock(8'd240, 8'd241, 8'd242, 8'd243, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL mid_fill_a: got %0d expected 20", lat); end
    do_lock(8'd244, 8'd245, 8'd246, 8'd247, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL mid_fill_b: got %0d expected 20", lat); end
    set_cells(8'd248, 8'd249, 8'd250, 8'd251);
    bus.Lock_Req = 1'b1;
    tick();
    bus.Lock_Req = 1'b0;
    tick();
    tick();
    // First SHIFT cycle: row 17 still full
    bus.Rd_Addr = 8'd238;
    #1;
    n_checks++; if (bus.Rd_Data !== 1'b1) begin n_fail++; $display("FAIL mid_pre_shift: got %b expected 1", bus.Rd_Data); end
    tick();
    // Row 17 now holds old (empty) row 16
    #1;
    n_checks++; if (bus.Rd_Data !== 1'b0) begin n_fail++; $display("FAIL mid_post_shift: got %b expected 0", bus.Rd_Data); end
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", bus.Busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.Busy !== 1'b0 || bus.Lock_Done !== 1'b0 || bus.Lines_Cleared !== 3'd0) begin
      n_fail++; $display("FAIL mid_rst_status: got busy=%b ld=%b lines=%0d expected 0 0 0", bus.Busy, bus.Lock_Done, bus.Lines_Cleared);
    end
    for (int a = 0; a < 256; a++) begin
      bus.Rd_Addr = 8'(a);
      #1;
      n_checks++; if (bus.Rd_Data !== 1'b0) begin n_fail++; $display("FAIL mid_rst_board addr=%0d: got %b expected 0", a, bus.Rd_Data); end
    end
    seen_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.Lock_Done || bus.Busy) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_quiet: got %b expected 0", seen_done); end
  endtask

  task automatic test_top_out();
    int lat;
    bit saw;
    do_lock(8'd0, 8'd1, 8'hFF, 8'hFF, 1'b0, lat, saw);
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL top_latency: got %0d expected 20", lat); end
    n_checks++; if (bus.Top_Out !== 1'b1) begin n_fail++; $display("FAIL top_set: got %b expected 1", bus.Top_Out); end
    do_lock(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, lat, saw);
    n_checks++; if (bus.Top_Out !== 1'b1) begin n_fail++; $display("FAIL top_sticky: got %b expected 1", bus.Top_Out); end
    bus.Clr_Board = 1'b1;
    tick();
    bus.Clr_Board = 1'b0;
    n_checks++; if (bus.Top_Out !== 1'b0) begin n_fail++; $display("FAIL top_wipe: got %b expected 0", bus.Top_Out); end
    bus.Rd_Addr = 8'd0;
    #1;
    n_checks++; if (bus.Rd_Data !== 1'b0) begin n_fail++; $display("FAIL top_wipe_cell: got %b expected 0", bus.Rd_Data); end
    tick();
    do_lock(8'd5, 8'hFF, 8'hFF, 8'hFF, 1'b0, lat, saw);
    n_checks++; if (bus.Top_Out !== 1'b1) begin n_fail++; $display("FAIL top_set2: got %b expected 1", bus.Top_Out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.Top_Out !== 1'b0) begin n_fail++; $display("FAIL top_rst: got %b expected 0", bus.Top_Out); end
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    n_checks      = 0;
    n_fail        = 0;
    bus.Clr_Board = 1'b0;
    bus.Cur_1     = 8'hFF;
    bus.Cur_2     = 8'hFF;
    bus.Cur_3     = 8'hFF;
    bus.Cur_4     = 8'hFF;
    bus.Pos_X     = '0;
    bus.Pos_Y     = '0;
    bus.Width     = '0;
    bus.Height    = '0;
    bus.Check_Req = 1'b0;
    bus.Lock_Req  = 1'b0;
    bus.Rd_Addr   = '0;
    tick();
    tick();
    test_reset();
    test_bounds();
    test_lock_o();
    test_clear_one();
    test_clear_four();
    test_both_req();
    test_busy_drop();
    test_reset_mid_shift();
    test_top_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
